// File: rtl/uart_tx_scheduler_if.sv
// Bus between the requesters/transmitter side and uart_tx_scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    i_Req;
    logic [16*NUM_REQ-1:0] i_Frame;
    logic [NUM_REQ-1:0]    o_Grant;
    logic [NUM_REQ-1:0]    o_Ack;
    logic                  o_Timeout;
    logic                  o_Busy;
    logic                  o_Tx_DV;
    logic [7:0]            o_Tx_Byte;
    logic                  i_Tx_Active;
    logic                  i_Tx_Done;

    modport slave (
        input  i_Req, i_Frame, i_Tx_Active, i_Tx_Done,
        output o_Grant, o_Ack, o_Timeout, o_Busy, o_Tx_DV, o_Tx_Byte
    );

    modport master (
        output i_Req, i_Frame, i_Tx_Active, i_Tx_Done,
        input  o_Grant, o_Ack, o_Timeout, o_Busy, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters.
// Each grant sends a 2-byte frame (byte0 first), then acks the owner.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 2,
    parameter int TIMEOUT_CLKS = 65536
) (
    input  logic               i_Clock,
    input  logic               i_Rst_n,
    uart_tx_scheduler_if.slave io_Bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ACK, S_GAP} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_sel;
    logic          w_found;
    logic [15:0]   r_frame;
    logic          r_byteIdx;
    logic [TW-1:0] r_toCnt;
    logic [7:0]    r_gapCnt;
    logic          r_abort;
    logic          r_txDv;
    logic [7:0]    r_txByte;
    logic          r_doneQ;
    logic          w_txIdle;
    logic          w_doneRise;
    logic          w_timeoutHit;
    logic          w_gapDone;

    assign w_txIdle     = !io_Bus.i_Tx_Active && !io_Bus.i_Tx_Done;
    assign w_doneRise   = io_Bus.i_Tx_Done && !r_doneQ;
    assign w_timeoutHit = (r_toCnt == TW'(TIMEOUT_CLKS - 1));
    assign w_gapDone    = (r_gapCnt == 8'(GAP_CLKS - 1));

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && io_Bus.i_Req[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_sel   = IW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (w_found) w_nextState = S_LOAD;
            S_LOAD: if (w_txIdle) w_nextState = S_WAIT;
            S_WAIT: begin
                if (w_doneRise) begin
                    w_nextState = r_byteIdx ? S_ACK : S_LOAD;
                end else if (w_timeoutHit) begin
                    w_nextState = S_ACK;
                end
            end
            S_ACK:  w_nextState = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (w_gapDone) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        io_Bus.o_Grant   = '0;
        io_Bus.o_Ack     = '0;
        io_Bus.o_Timeout = 1'b0;
        io_Bus.o_Busy    = (r_state != S_IDLE);
        case (r_state)
            S_LOAD, S_WAIT: io_Bus.o_Grant[r_owner] = 1'b1;
            S_ACK: begin
                io_Bus.o_Grant[r_owner] = 1'b1;
                io_Bus.o_Ack[r_owner]   = 1'b1;
                io_Bus.o_Timeout        = r_abort;
            end
            default: ;
        endcase
    end

    assign io_Bus.o_Tx_DV   = r_txDv;
    assign io_Bus.o_Tx_Byte = r_txByte;

    // Frame is captured only at grant; DV is held off until the transmitter
    // has fully finished so it can never be dropped.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_frame   <= '0;
            r_byteIdx <= 1'b0;
            r_toCnt   <= '0;
            r_gapCnt  <= '0;
            r_abort   <= 1'b0;
            r_txDv    <= 1'b0;
            r_txByte  <= '0;
            r_doneQ   <= 1'b0;
        end else begin
            r_doneQ <= io_Bus.i_Tx_Done;
            r_txDv  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_sel;
                        r_frame   <= io_Bus.i_Frame[16*w_sel +: 16];
                        r_byteIdx <= 1'b0;
                        r_ptr     <= (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_txIdle) begin
                        r_txDv   <= 1'b1;
                        r_txByte <= r_byteIdx ? r_frame[15:8] : r_frame[7:0];
                        r_toCnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_doneRise) begin
                        r_byteIdx <= 1'b1;
                    end else if (w_timeoutHit) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                end
                S_ACK: begin
                    r_abort  <= 1'b0;
                    r_gapCnt <= '0;
                end
                S_GAP: r_gapCnt <= r_gapCnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a 4-clock-per-bit UART transmitter model as the
// load, a serial receiver feeding a byte scoreboard, and a short-timeout instance.
module tb_uart_tx_scheduler;
    localparam int NUM_REQ    = 4;
    localparam int GAP_CLKS   = 2;
    localparam int TO_SHORT   = 8;
    localparam int WAIT_LIMIT = 600;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();
    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) toBus ();

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS), .TIMEOUT_CLKS(65536)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .io_Bus(bus));

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS), .TIMEOUT_CLKS(TO_SHORT)) dutTo (
        .i_Clock(clk), .i_Rst_n(rst_n), .io_Bus(toBus));

    always #5 clk = ~clk;

    typedef struct {
        int          reqIdx;
        logic [15:0] frame;
        logic [3:0]  expGrant;
    } vec_t;

    int        checkCnt = 0;
    int        passCnt = 0;
    int        dvCount = 0;
    int        ackCount = 0;
    int        mainTmoCount = 0;
    int        lostDvCount = 0;
    logic [7:0] expQ[$];
    bit        rxEnable = 1'b1;

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, then a 2-clock done.
    logic       txActive;
    logic       txDone;
    logic       txSerial;
    logic [9:0] shReg;
    int         bitIdx;
    int         clkCnt;
    int         doneCnt;

    assign txSerial = txActive ? shReg[bitIdx] : 1'b1;
    assign txDone   = (doneCnt != 0);
    assign bus.i_Tx_Active   = txActive;
    assign bus.i_Tx_Done     = txDone;
    assign toBus.i_Tx_Active = 1'b0;
    assign toBus.i_Tx_Done   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txActive <= 1'b0;
            shReg    <= '1;
            bitIdx   <= 0;
            clkCnt   <= 0;
            doneCnt  <= 0;
        end else begin
            if (doneCnt != 0) doneCnt <= doneCnt - 1;
            if (!txActive) begin
                if (bus.o_Tx_DV) begin
                    shReg    <= {1'b1, bus.o_Tx_Byte, 1'b0};
                    txActive <= 1'b1;
                    bitIdx   <= 0;
                    clkCnt   <= 0;
                end
            end else if (clkCnt == 3) begin
                clkCnt <= 0;
                if (bitIdx == 9) begin
                    txActive <= 1'b0;
                    doneCnt  <= 2;
                end else begin
                    bitIdx <= bitIdx + 1;
                end
            end else begin
                clkCnt <= clkCnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.o_Tx_DV) begin
            dvCount++;
            if (txActive || txDone) lostDvCount++;
        end
        if (bus.o_Ack != '0) ackCount++;
        if (bus.o_Timeout) mainTmoCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    endtask

    task automatic reportTimeout(input string name);
        checkCnt++;
        $display("[TB] FAIL %s: nothing after %0d cycles, required a response", name, WAIT_LIMIT);
    endtask

    // Serial receiver: samples mid-bit and checks each byte against the scoreboard.
    initial begin
        logic [7:0] rxByte;
        forever begin
            @(negedge txSerial);
            repeat (2) @(posedge clk);
            if (txSerial == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    rxByte[i] = txSerial;
                end
                repeat (4) @(posedge clk);
                if (rxEnable) begin
                    checkOutput("rx_stop_bit", 32'(txSerial), 32'd1);
                    if (expQ.size() == 0) begin
                        checkCnt++;
                        $display("[TB] FAIL rx_unexpected: got byte %02h, required none", rxByte);
                    end else begin
                        checkOutput("rx_byte", 32'(rxByte), 32'(expQ.pop_front()));
                    end
                end
            end
        end
    end

    task automatic waitGrant(input bit useTo, output logic [3:0] g, output int cycles);
        g = '0;
        cycles = 0;
        while (g == '0 && cycles < WAIT_LIMIT) begin
            @(negedge clk);
            cycles++;
            g = useTo ? toBus.o_Grant : bus.o_Grant;
        end
        if (g == '0) reportTimeout("grant_wait");
    endtask

    task automatic waitAck(input bit useTo, output logic [3:0] a, output logic tmo, output int cycles);
        a = '0;
        tmo = 1'b0;
        cycles = 0;
        while (a == '0 && cycles < WAIT_LIMIT) begin
            @(negedge clk);
            cycles++;
            a   = useTo ? toBus.o_Ack : bus.o_Ack;
            tmo = useTo ? toBus.o_Timeout : bus.o_Timeout;
        end
        if (a == '0) reportTimeout("ack_wait");
    endtask

    task automatic waitDv(input bit useTo, output int cycles);
        logic dv;
        dv = 1'b0;
        cycles = 0;
        while (!dv && cycles < WAIT_LIMIT) begin
            @(negedge clk);
            cycles++;
            dv = useTo ? toBus.o_Tx_DV : bus.o_Tx_DV;
        end
        if (!dv) reportTimeout("dv_wait");
    endtask

    task automatic applyStimulus(input vec_t v);
        expQ.push_back(v.frame[7:0]);
        expQ.push_back(v.frame[15:8]);
        bus.i_Frame[16*v.reqIdx +: 16] = v.frame;
        bus.i_Req[v.reqIdx] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[4];
        logic [3:0] g;
        logic [3:0] a;
        logic       tmo;
        int         cyc;
        int         dvStart;
        int         ackBefore;
        int         ord[5];

        vecs[0] = '{reqIdx: 0, frame: 16'hA55A, expGrant: 4'b0001};
        vecs[1] = '{reqIdx: 1, frame: 16'h0FF0, expGrant: 4'b0010};
        vecs[2] = '{reqIdx: 3, frame: 16'h8001, expGrant: 4'b1000};
        vecs[3] = '{reqIdx: 2, frame: 16'h7E00, expGrant: 4'b0100};
        ord = '{0, 1, 2, 3, 0};

        bus.i_Req     = '0;
        bus.i_Frame   = '0;
        toBus.i_Req   = '0;
        toBus.i_Frame = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_grant", 32'(bus.o_Grant), 32'd0);
        checkOutput("reset_busy", 32'(bus.o_Busy), 32'd0);
        checkOutput("reset_dv", 32'(bus.o_Tx_DV), 32'd0);
        checkOutput("reset_byte", 32'(bus.o_Tx_Byte), 32'd0);

        $display("[TB] all requesters held from reset");
        bus.i_Frame = {16'hB3A3, 16'hB2A2, 16'hB1A1, 16'hB0A0};
        bus.i_Req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expQ.push_back(8'hA0 + 8'(ord[k]));
            expQ.push_back(8'hB0 + 8'(ord[k]));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            waitGrant(1'b0, g, cyc);
            checkOutput("rr_grant", 32'(g), 32'(1) << ord[k]);
            // Ack cycle, GAP_CLKS gap clocks, one idle clock, then the grant appears.
            if (k > 0) checkOutput("rr_gap_clks", 32'(cyc), 32'(GAP_CLKS + 2));
            waitAck(1'b0, a, tmo, cyc);
            checkOutput("rr_ack", 32'(a), 32'(g));
            if (k == 4) bus.i_Req = '0;
        end
        checkOutput("rr_dv_count", 32'(dvCount), 32'd10);
        repeat (GAP_CLKS + 1) @(negedge clk);

        $display("[TB] pointer at 2 with requesters 1 and 3");
        bus.i_Frame[31:16] = 16'hC301;
        bus.i_Frame[63:48] = 16'h3C03;
        expQ.push_back(8'h01); expQ.push_back(8'hC3);
        expQ.push_back(8'h03); expQ.push_back(8'h3C);
        expQ.push_back(8'h01); expQ.push_back(8'hC3);
        bus.i_Req = 4'b0010;
        waitGrant(1'b0, g, cyc);
        checkOutput("ptr_first_grant", 32'(g), 32'h2);
        bus.i_Req = 4'b1010;
        waitAck(1'b0, a, tmo, cyc);
        waitGrant(1'b0, g, cyc);
        checkOutput("ptr_grant_req3", 32'(g), 32'h8);
        bus.i_Req = 4'b0010;
        waitAck(1'b0, a, tmo, cyc);
        checkOutput("ptr_ack_req3", 32'(a), 32'h8);
        waitGrant(1'b0, g, cyc);
        checkOutput("ptr_grant_req1", 32'(g), 32'h2);
        bus.i_Req = '0;
        waitAck(1'b0, a, tmo, cyc);
        checkOutput("ptr_ack_req1", 32'(a), 32'h2);
        repeat (GAP_CLKS + 1) @(negedge clk);

        $display("[TB] reset while waiting for a byte");
        bus.i_Frame[15:0] = 16'h3C3C;
        bus.i_Req = 4'b0001;
        waitGrant(1'b0, g, cyc);
        waitDv(1'b0, cyc);
        repeat (10) @(negedge clk);
        checkOutput("midframe_busy", 32'(bus.o_Busy), 32'd1);
        rxEnable = 1'b0;
        ackBefore = ackCount;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_grant", 32'(bus.o_Grant), 32'd0);
        checkOutput("rst_ack", 32'(bus.o_Ack), 32'd0);
        checkOutput("rst_busy", 32'(bus.o_Busy), 32'd0);
        checkOutput("rst_byte", 32'(bus.o_Tx_Byte), 32'd0);
        bus.i_Req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("rst_no_ack", 32'(ackCount), 32'(ackBefore));
        checkOutput("rst_idle_busy", 32'(bus.o_Busy), 32'd0);
        rxEnable = 1'b1;

        $display("[TB] single-requester frame table");
        for (int k = 0; k < 4; k++) begin
            dvStart = dvCount;
            applyStimulus(vecs[k]);
            waitGrant(1'b0, g, cyc);
            checkOutput("vec_grant", 32'(g), 32'(vecs[k].expGrant));
            checkOutput("vec_grant_latency", 32'(cyc), 32'd1);
            waitDv(1'b0, cyc);
            checkOutput("vec_dv_latency", 32'(cyc), 32'd1);
            waitAck(1'b0, a, tmo, cyc);
            checkOutput("vec_ack", 32'(a), 32'(vecs[k].expGrant));
            checkOutput("vec_timeout", 32'(tmo), 32'd0);
            bus.i_Req = '0;
            checkOutput("vec_dv_count", 32'(dvCount - dvStart), 32'd2);
            repeat (GAP_CLKS + 1) @(negedge clk);
            checkOutput("vec_idle_busy", 32'(bus.o_Busy), 32'd0);
        end

        $display("[TB] frame changed and request dropped after grant");
        bus.i_Frame[47:32] = 16'hBEEF;
        expQ.push_back(8'hEF);
        expQ.push_back(8'hBE);
        bus.i_Req = 4'b0100;
        waitGrant(1'b0, g, cyc);
        checkOutput("late_grant", 32'(g), 32'h4);
        bus.i_Frame[47:32] = 16'h1234;
        bus.i_Req = '0;
        waitAck(1'b0, a, tmo, cyc);
        checkOutput("late_ack", 32'(a), 32'h4);
        repeat (GAP_CLKS + 1) @(negedge clk);

        $display("[TB] short timeout instance with done tied low");
        toBus.i_Frame[15:0]  = 16'h6655;
        toBus.i_Frame[31:16] = 16'h7766;
        toBus.i_Req = 4'b0011;
        waitDv(1'b1, cyc);
        checkOutput("to_grant_at_dv", 32'(toBus.o_Grant), 32'h1);
        checkOutput("to_dv_byte", 32'(toBus.o_Tx_Byte), 32'h55);
        waitAck(1'b1, a, tmo, cyc);
        checkOutput("to_ack_delay", 32'(cyc), 32'(TO_SHORT));
        checkOutput("to_ack", 32'(a), 32'h1);
        checkOutput("to_timeout_flag", 32'(tmo), 32'd1);
        toBus.i_Req = 4'b0010;
        waitGrant(1'b1, g, cyc);
        checkOutput("to_next_grant", 32'(g), 32'h2);
        toBus.i_Req = '0;
        waitAck(1'b1, a, tmo, cyc);
        checkOutput("to_second_ack", 32'(a), 32'h2);
        checkOutput("to_second_timeout", 32'(tmo), 32'd1);

        repeat (5) @(negedge clk);
        checkOutput("bytes_outstanding", 32'(expQ.size()), 32'd0);
        checkOutput("main_timeouts", 32'(mainTmoCount), 32'd0);
        checkOutput("dv_while_busy", 32'(lostDvCount), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
